dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single data-memory port between the CPU load/store path (port A) and the serial program loader/debug path (port B).
- Latches one request at a time and drives the memory strobes for exactly one cycle. Returns a registered response with a one-cycle ack.
- Rejects access forms the data memory does not support: sub-word reads and misaligned word accesses.
- Sits between both requesters and the data-memory address space (stack, static data, serial MMIO).

Parameters:
- RR_MODE, 1: 1 = round-robin; 0 = fixed priority, A always wins.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held high until a_ack.
- a_we  in  1  A write (1) / read (0).
- a_addr  in  ADDR_W  A byte address.
- a_wdata  in  DATA_W  A write data.
- a_size  in  2  A size; 2'b11 = word.
- a_ack  out  1  A one-cycle completion pulse.
- a_err  out  1  A error, valid with a_ack.
- a_rdata  out  DATA_W  A read data, valid with a_ack.
- b_req, b_we, b_addr, b_wdata, b_size, b_ack, b_err, b_rdata: same as the A ports, for port B.
- mem_addr  out  ADDR_W  to the data memory.
- mem_wdata  out  DATA_W  to the data memory.
- mem_re  out  1  to the data memory.
- mem_we  out  1  to the data memory.
- mem_size  out  2  to the data memory.
- mem_rdata  in  DATA_W  combinational read data from the data memory.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; last_grant=B, so A wins the first tie.
  - All acks, errs, mem_re, mem_we and busy = 0.
  - All data, address and size outputs = 0.
  - A write sitting in ISSUE when reset asserts is not committed, because mem_we drops immediately.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - mem_re=mem_we=0.
  - If no req is high, stay in IDLE.
  - Otherwise choose the winner:
    - Only one req high: that port wins.
    - Both high and RR_MODE=1: the port != last_grant wins.
    - Both high and RR_MODE=0: A wins.
  - Latch the winner's we/addr/wdata/size, set last_grant=winner, go to ISSUE.
- Error check (done on the latched request):
  - err if size==2'b11 and addr[1:0]!=0 (misaligned word).
  - err if we==0 and size!=2'b11 (unsupported sub-word read).
- ISSUE (exactly one cycle):
  - mem_addr/mem_wdata/mem_size are driven from the latched registers.
  - mem_re=~we & ~err; mem_we=we & ~err. An erroring request never strobes memory.
  - At the clock edge: capture mem_rdata into the rdata register for non-error reads; otherwise the captured value is 0. Then go to RESP.
- RESP (one cycle):
  - Winner's ack=1, err=latched err, rdata=captured value.
  - The loser's ack, err and rdata stay 0.
  - Then go to IDLE.
- Latency and throughput:
  - Request sampled in cycle N → memory strobe in N+1 → ack in N+2.
  - Maximum throughput is one transaction per 3 cycles.
- Requester rule: req must drop in the cycle after ack. A req still high in IDLE is a new request.
- Request changes: a_*/b_* changes while req is high and before ack are ignored once latched. A req dropped before it is latched is simply not serviced.
- Fairness: with both requesters saturating in RR_MODE=1, grants strictly alternate A,B,A,B.
- Outside RESP: rdata outputs hold their last value; ack and err are 0.

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2);
  - SIZE_WORD=2'b11;
  - port-id constants PORT_A=1'b0, PORT_B=1'b1;
  - segment base constants 16'h1000, 16'h7fff, 16'hffff.
- One natural sub-module, rr_arb2: a 2-input round-robin/fixed-priority chooser holding last_grant, with a grant-enable input. The FSM, latching and error check stay in dmem_arbiter.

Test Plan:
- Reset, then a_req=1 write addr 0x10000010 wdata 0xDEADBEEF size 11 → mem_we=1 for exactly 1 cycle at N+1; a_ack at N+2 with a_err=0. A following A read of 0x10000010 → a_rdata=0xDEADBEEF.
- Both requests held high continuously (A reads 0x7ffff000, B reads 0x10000000) in RR_MODE=1 → ack order A,B,A,B; each ack 3 cycles apart; b_ack never coincides with a_ack.
- Same stimulus with RR_MODE=0 and A re-requesting immediately after each ack → only A is acked while A keeps requesting; B is acked only in a cycle where a_req=0 in IDLE.
- A write size 11 to addr 0x10000002 → mem_we stays 0 throughout; a_ack=1, a_err=1. B read size 2'b00 → mem_re stays 0; b_ack=1, b_err=1, b_rdata=0.
- Assert reset in the ISSUE cycle of a write 0x12345678 to 0x10000020 → mem_we falls immediately; all outputs are 0 and state=IDLE. A later read of 0x10000020 returns the pre-write value.
- Read of serial MMIO 0xffff0000 with mem_rdata=0x00000041 → a_rdata=0x00000041 at ack. mem_rdata changing to 0 in RESP does not alter a_rdata.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state
// encoding, access-size and port-id constants, address-map segment bases,
// and the access-legality check applied to a latched request.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Upper-halfword bases of the data-memory segments.
    localparam logic [15:0] SEG_DATA_BASE = 16'h1000;
    localparam logic [15:0] SEG_STACK_TOP = 16'h7fff;
    localparam logic [15:0] SEG_MMIO_BASE = 16'hffff;

    // The memory only serves aligned word accesses for reads; writes may be
    // sub-word, but a word write must still be aligned.
    function automatic logic access_err(input logic       we,
                                        input logic [1:0] addr_lo,
                                        input logic [1:0] size);
        logic misaligned_word;
        logic subword_read;
        misaligned_word = (size == SIZE_WORD) && (addr_lo != 2'b00);
        subword_read    = !we && (size != SIZE_WORD);
        return misaligned_word || subword_read;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The master side is the requesters plus the memory model; the slave side
// is the arbiter itself.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [1:0]        a_size;
    logic              a_ack;
    logic              a_err;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [1:0]        b_size;
    logic              b_ack;
    logic              b_err;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_size,
        input  a_ack, a_err, a_rdata,
        output b_req, b_we, b_addr, b_wdata, b_size,
        input  b_ack, b_err, b_rdata,
        input  mem_addr, mem_wdata, mem_re, mem_we, mem_size,
        output mem_rdata,
        input  busy
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_size,
        output a_ack, a_err, a_rdata,
        input  b_req, b_we, b_addr, b_wdata, b_size,
        output b_ack, b_err, b_rdata,
        output mem_addr, mem_wdata, mem_re, mem_we, mem_size,
        input  mem_rdata,
        output busy
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input chooser. In round-robin mode a tie goes to the port that did
// not win last; in fixed mode port A always wins a tie. last_grant only
// advances when the caller enables a grant and some request is present.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter bit RR_MODE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic en,
    output logic grant,
    output logic grant_vld
);

    logic last_grant_q;
    logic last_grant_d;

    // Pick a winner and compute the next last_grant.
    always_comb begin
        grant_vld    = req_a | req_b;
        grant        = PORT_A;
        last_grant_d = last_grant_q;
        if (req_a && req_b) begin
            if (RR_MODE) begin
                grant = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
            end else begin
                grant = PORT_A;
            end
        end else if (req_b) begin
            grant = PORT_B;
        end
        if (en && grant_vld) begin
            last_grant_d = grant;
        end
    end

    // last_grant starts at B so that A wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= PORT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path (A)
// and the serial loader/debug path (B). One request is latched at a time,
// strobed to memory for one cycle, and answered with a registered one-cycle
// ack. Illegal access forms are acked with err and never reach memory.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter bit RR_MODE = 1'b1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    state_t            state_q,   state_d;
    logic              winner_q,  winner_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [1:0]        size_q,    size_d;
    logic              a_ack_q,   a_ack_d;
    logic              a_err_q,   a_err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic              b_ack_q,   b_ack_d;
    logic              b_err_q,   b_err_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic              grant;
    logic              grant_vld;
    logic              grant_en;
    logic              req_err;
    logic              in_issue;
    logic [DATA_W-1:0] cap_rdata;

    rr_arb2 #(
        .RR_MODE (RR_MODE)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req_a     (bus.a_req),
        .req_b     (bus.b_req),
        .en        (grant_en),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    assign req_err   = access_err(we_q, addr_q[1:0], size_q);
    assign in_issue  = (state_q == ISSUE);
    // Only a legal read returns memory data; writes and errors return zero.
    assign cap_rdata = (!we_q && !req_err) ? bus.mem_rdata : '0;

    // Next-state, request latching and response generation.
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        a_ack_d   = 1'b0;
        a_err_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_ack_d   = 1'b0;
        b_err_d   = 1'b0;
        b_rdata_d = b_rdata_q;
        grant_en  = 1'b0;

        case (state_q)
            IDLE: begin
                grant_en = 1'b1;
                if (grant_vld) begin
                    winner_d = grant;
                    if (grant == PORT_A) begin
                        we_d    = bus.a_we;
                        addr_d  = bus.a_addr;
                        wdata_d = bus.a_wdata;
                        size_d  = bus.a_size;
                    end else begin
                        we_d    = bus.b_we;
                        addr_d  = bus.b_addr;
                        wdata_d = bus.b_wdata;
                        size_d  = bus.b_size;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The response registers load here so ack appears in RESP.
                if (winner_q == PORT_A) begin
                    a_ack_d   = 1'b1;
                    a_err_d   = req_err;
                    a_rdata_d = cap_rdata;
                end else begin
                    b_ack_d   = 1'b1;
                    b_err_d   = req_err;
                    b_rdata_d = cap_rdata;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            winner_q  <= PORT_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= 2'b00;
            a_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_ack_q   <= 1'b0;
            b_err_q   <= 1'b0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            a_ack_q   <= a_ack_d;
            a_err_q   <= a_err_d;
            a_rdata_q <= a_rdata_d;
            b_ack_q   <= b_ack_d;
            b_err_q   <= b_err_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Memory strobes exist only in ISSUE, so an async reset there drops
    // them at once and an in-flight write is never committed.
    assign bus.mem_re    = in_issue & ~we_q & ~req_err;
    assign bus.mem_we    = in_issue &  we_q & ~req_err;
    assign bus.mem_addr  = in_issue ? addr_q  : '0;
    assign bus.mem_wdata = in_issue ? wdata_q : '0;
    assign bus.mem_size  = in_issue ? size_q  : 2'b00;

    assign bus.a_ack   = a_ack_q;
    assign bus.a_err   = a_err_q;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_ack   = b_ack_q;
    assign bus.b_err   = b_err_q;
    assign bus.b_rdata = b_rdata_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one round-robin instance and one fixed-priority
// instance, each with a small word-addressed memory model. Expected acks
// are queued when stimulus is issued and checked by a separate monitor.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    typedef struct {
        int          dut;
        bit          port;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n0;
    logic rst_n1;
    logic ovr0;
    logic [31:0] ovr_val0;
    bit mem_clr;

    logic [31:0] mem0 [0:255];
    logic [31:0] mem1 [0:255];

    exp_t sbq[$];
    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

    dmem_arbiter #(.RR_MODE(1'b1), .ADDR_W(32), .DATA_W(32)) dut0 (
        .clock (clk),
        .reset (rst_n0),
        .bus   (if0)
    );

    dmem_arbiter #(.RR_MODE(1'b0), .ADDR_W(32), .DATA_W(32)) dut1 (
        .clock (clk),
        .reset (rst_n1),
        .bus   (if1)
    );

    always #5 clk = ~clk;

    // Memory models: combinational read, write on rising edge.
    assign if0.mem_rdata = ovr0 ? ovr_val0 : mem0[if0.mem_addr[9:2]];
    assign if1.mem_rdata = mem1[if1.mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 32'hA500_0000 | i;
                mem1[i] <= 32'hA500_0000 | i;
            end
        end else if (if0.mem_we) begin
            mem0[if0.mem_addr[9:2]] <= if0.mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic mon_one(input int d, input bit p, input logic err, input logic [31:0] rd);
        int idx = -1;
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].dut == d) begin
                idx = i;
                break;
            end
        end
        if (idx < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected dut%0d: got ack on port %0d, expected no ack", d, p);
            return;
        end
        chk($sformatf("sb_port dut%0d", d), {31'd0, p}, {31'd0, sbq[idx].port});
        chk($sformatf("sb_err dut%0d", d), {31'd0, err}, {31'd0, sbq[idx].err});
        chk($sformatf("sb_rdata dut%0d", d), rd, sbq[idx].rdata);
        sbq.delete(idx);
    endtask

    // Monitor: every ack is matched against the oldest expectation for that DUT.
    always @(negedge clk) begin
        if (if0.a_ack) mon_one(0, PORT_A, if0.a_err, if0.a_rdata);
        if (if0.b_ack) mon_one(0, PORT_B, if0.b_err, if0.b_rdata);
        if (if0.a_ack || if0.b_ack) chk("ack_excl dut0", {31'd0, if0.a_ack & if0.b_ack}, 32'd0);
        if (if1.a_ack) mon_one(1, PORT_A, if1.a_err, if1.a_rdata);
        if (if1.b_ack) mon_one(1, PORT_B, if1.b_err, if1.b_rdata);
        if (if1.a_ack || if1.b_ack) chk("ack_excl dut1", {31'd0, if1.a_ack & if1.b_ack}, 32'd0);
    end

    task automatic drive0(input bit port, input bit req, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size);
        if (port == PORT_A) begin
            if0.a_req = req; if0.a_we = we; if0.a_addr = addr;
            if0.a_wdata = wdata; if0.a_size = size;
        end else begin
            if0.b_req = req; if0.b_we = we; if0.b_addr = addr;
            if0.b_wdata = wdata; if0.b_size = size;
        end
    endtask

    // One transaction on dut0 with cycle-exact strobe and ack timing checks.
    task automatic txn(input string nm, input bit port, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input bit exp_err,
                       input logic [31:0] exp_rd, input bit zap);
        sbq.push_back('{dut: 0, port: port, err: exp_err, rdata: exp_rd});
        @(posedge clk); #1;
        drive0(port, 1'b1, we, addr, wdata, size);
        @(negedge clk);
        chk({nm, " N mem_we"}, {31'd0, if0.mem_we}, 32'd0);
        chk({nm, " N mem_re"}, {31'd0, if0.mem_re}, 32'd0);
        @(negedge clk);
        chk({nm, " N+1 mem_we"}, {31'd0, if0.mem_we}, {31'd0, we & ~exp_err});
        chk({nm, " N+1 mem_re"}, {31'd0, if0.mem_re}, {31'd0, ~we & ~exp_err});
        chk({nm, " N+1 mem_addr"}, if0.mem_addr, addr);
        chk({nm, " N+1 mem_size"}, {30'd0, if0.mem_size}, {30'd0, size});
        chk({nm, " N+1 busy"}, {31'd0, if0.busy}, 32'd1);
        @(posedge clk); #1;
        if (zap) ovr_val0 = 32'h0;
        @(negedge clk);
        chk({nm, " N+2 ack"}, {31'd0, (port == PORT_A) ? if0.a_ack : if0.b_ack}, 32'd1);
        chk({nm, " N+2 mem_we"}, {31'd0, if0.mem_we | if0.mem_re}, 32'd0);
        @(posedge clk); #1;
        drive0(port, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    endtask

    initial begin
        bit ea, eb;
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        ovr0 = 1'b0; ovr_val0 = 32'h0; mem_clr = 1'b1;
        drive0(PORT_A, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        drive0(PORT_B, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        if1.a_req = 1'b0; if1.a_we = 1'b0; if1.a_addr = 32'h0; if1.a_wdata = 32'h0; if1.a_size = 2'b00;
        if1.b_req = 1'b0; if1.b_we = 1'b0; if1.b_addr = 32'h0; if1.b_wdata = 32'h0; if1.b_size = 2'b00;
        #1 rst_n0 = 1'b0; rst_n1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", {31'd0, if0.busy}, 32'd0);
        chk("rst acks", {30'd0, if0.a_ack, if0.b_ack}, 32'd0);
        chk("rst errs", {30'd0, if0.a_err, if0.b_err}, 32'd0);
        chk("rst strobes", {30'd0, if0.mem_re, if0.mem_we}, 32'd0);
        chk("rst mem_addr", if0.mem_addr, 32'd0);
        chk("rst mem_wdata", if0.mem_wdata, 32'd0);
        chk("rst a_rdata", if0.a_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n0 = 1'b1; rst_n1 = 1'b1; mem_clr = 1'b0;

        // Word write then read-back.
        txn("wr1", PORT_A, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, SIZE_WORD, 1'b0, 32'h0, 1'b0);
        txn("rd1", PORT_A, 1'b0, 32'h1000_0010, 32'h0, SIZE_WORD, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Illegal forms: misaligned word write, sub-word read.
        txn("mis", PORT_A, 1'b1, 32'h1000_0002, 32'h1111_2222, SIZE_WORD, 1'b1, 32'h0, 1'b0);
        txn("sub", PORT_B, 1'b0, 32'h1000_0000, 32'h0, 2'b00, 1'b1, 32'h0, 1'b0);

        // Reset while a write is in ISSUE: nothing is committed.
        @(posedge clk); #1;
        drive0(PORT_A, 1'b1, 1'b1, 32'h1000_0020, 32'h1234_5678, SIZE_WORD);
        @(negedge clk);
        @(negedge clk);
        chk("rstwr issue mem_we", {31'd0, if0.mem_we}, 32'd1);
        #1 rst_n0 = 1'b0;
        #1;
        chk("rstwr mem_we", {31'd0, if0.mem_we}, 32'd0);
        chk("rstwr busy", {31'd0, if0.busy}, 32'd0);
        chk("rstwr mem_addr", if0.mem_addr, 32'd0);
        chk("rstwr mem_wdata", if0.mem_wdata, 32'd0);
        chk("rstwr a_ack", {31'd0, if0.a_ack}, 32'd0);
        drive0(PORT_A, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        @(posedge clk); #1;
        rst_n0 = 1'b1;
        txn("rstrd", PORT_A, 1'b0, 32'h1000_0020, 32'h0, SIZE_WORD, 1'b0, 32'hA500_0008, 1'b0);

        // Serial MMIO read; memory data drops to 0 during RESP.
        ovr0 = 1'b1; ovr_val0 = 32'h0000_0041;
        txn("mmio", PORT_A, 1'b0, 32'hFFFF_0000, 32'h0, SIZE_WORD, 1'b0, 32'h0000_0041, 1'b1);
        @(negedge clk);
        chk("mmio hold rdata", if0.a_rdata, 32'h0000_0041);
        chk("mmio ack low", {31'd0, if0.a_ack}, 32'd0);
        ovr0 = 1'b0;

        // Round-robin saturation from a fresh reset: A,B,A,B, 3 cycles apart.
        @(posedge clk); #1 rst_n0 = 1'b0;
        @(posedge clk); #1 rst_n0 = 1'b1;
        for (int i = 0; i < 4; i++)
            sbq.push_back('{dut: 0, port: (i % 2 == 1), err: 1'b0, rdata: 32'hA500_0000});
        @(posedge clk); #1;
        drive0(PORT_A, 1'b1, 1'b0, 32'h7FFF_F000, 32'h0, SIZE_WORD);
        drive0(PORT_B, 1'b1, 1'b0, 32'h1000_0000, 32'h0, SIZE_WORD);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ea = (k % 3 == 2) && ((k / 3) % 2 == 0);
            eb = (k % 3 == 2) && ((k / 3) % 2 == 1);
            chk($sformatf("rr a_ack k%0d", k), {31'd0, if0.a_ack}, {31'd0, ea});
            chk($sformatf("rr b_ack k%0d", k), {31'd0, if0.b_ack}, {31'd0, eb});
        end
        @(posedge clk); #1;
        drive0(PORT_A, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        drive0(PORT_B, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);

        // Fixed priority: B only gets in once A stops requesting.
        for (int i = 0; i < 5; i++)
            sbq.push_back('{dut: 1, port: (i == 4), err: 1'b0, rdata: 32'hA500_0000});
        @(posedge clk); #1;
        if1.a_req = 1'b1; if1.a_we = 1'b0; if1.a_addr = 32'h7FFF_F000; if1.a_size = SIZE_WORD;
        if1.b_req = 1'b1; if1.b_we = 1'b0; if1.b_addr = 32'h1000_0000; if1.b_size = SIZE_WORD;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            ea = (k < 12) && (k % 3 == 2);
            eb = (k == 14);
            chk($sformatf("fp a_ack k%0d", k), {31'd0, if1.a_ack}, {31'd0, ea});
            chk($sformatf("fp b_ack k%0d", k), {31'd0, if1.b_ack}, {31'd0, eb});
            if (k == 11) begin
                @(posedge clk); #1;
                if1.a_req = 1'b0;
            end
        end
        @(posedge clk); #1;
        if1.b_req = 1'b0;

        repeat (3) @(posedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
